max2d_window_buffer: RTL

- Upstream feeder for the 2x2 max-pooling layer.
- Accepts a clocked, row-major pixel stream on a valid/ready handshake. Each beat carries FILTER_IN channels.
- Buffers one image row, assembles non-overlapping 2x2 windows (stride 2), and presents each window to the asynchronous max2d layer as dual-rail data (xt/xf) using a four-phase return-to-spacer handshake on ack_nxt.
- This is the synchronous-to-asynchronous boundary in front of the pooling stage.

---
 rtl/max2d_window_buffer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/max2d_window_buffer.sv
// Sync-to-async boundary in front of the 2x2 max-pool layer: buffers one image row,
// forms stride-2 2x2 windows and issues them as dual-rail words with a four-phase handshake.
//
// state | meaning
// IDLE  | rails at spacer, waiting for a pending window and ack low
// DATA  | window on the rails (xt=window, xf=~window), waiting for ack high
// RTZ   | rails back at spacer, waiting for ack low

`ifndef BIT_DATA
`define BIT_DATA 8
`endif
`ifndef MAX2D_KSIZE
`define MAX2D_KSIZE 4
`endif

module max2d_window_buffer #(
   parameter int FILTER_IN = 32,
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [`BIT_DATA*FILTER_IN-1:0]              in_data,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   output logic [`BIT_DATA*`MAX2D_KSIZE*FILTER_IN-1:0] xt,
   output logic [`BIT_DATA*`MAX2D_KSIZE*FILTER_IN-1:0] xf,
   input  logic                                        ack_nxt,
   output logic                                        frame_done
);

   localparam int BD = `BIT_DATA;
   localparam int KS = `MAX2D_KSIZE;
   localparam int PW = BD * FILTER_IN;
   localparam int WW = BD * KS * FILTER_IN;
   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

   typedef enum logic [1:0] {IDLE, DATA, RTZ} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   col, col_m1;
   logic [RW-1:0]   row;
   logic            started;
   logic            pending, pend_last, cur_last;
   logic            ack_s1, ack_s2;
   logic [PW-1:0]   line_buf [IMG_W];
   logic [PW-1:0]   hold_px;
   logic [WW-1:0]   win_reg, win_nxt;
   logic [WW-1:0]   xt_nxt, xf_nxt;
   logic            done_nxt, consume, accept;
   logic            col_last, row_last, odd_odd;

   assign col_last = (col == CW'(IMG_W - 1));
   assign row_last = (row == RW'(IMG_H - 1));
   assign odd_odd  = row[0] & col[0];
   assign col_m1   = col - CW'(1);
   assign in_ready = started & ~(odd_odd & pending);
   assign accept   = in_valid & in_ready;

   // Element order per channel: line[col-1], line[col], held pixel, current pixel.
   always_comb begin
      win_nxt = '0;
      for (int i = 0; i < FILTER_IN; i++) begin
         win_nxt[i*BD*KS        +: BD] = line_buf[col_m1][i*BD +: BD];
         win_nxt[i*BD*KS + BD   +: BD] = line_buf[col][i*BD +: BD];
         win_nxt[i*BD*KS + 2*BD +: BD] = hold_px[i*BD +: BD];
         win_nxt[i*BD*KS + 3*BD +: BD] = in_data[i*BD +: BD];
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !row[0])
         line_buf[col] <= in_data;
      if (accept && row[0] && !col[0])
         hold_px <= in_data;
      if (accept && odd_odd)
         win_reg <= win_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         started   <= 1'b0;
         col       <= '0;
         row       <= '0;
         pending   <= 1'b0;
         pend_last <= 1'b0;
      end else begin
         started <= 1'b1;
         if (accept) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         // A load in the same cycle as a consume keeps pending set.
         if (accept && odd_odd) begin
            pending   <= 1'b1;
            pend_last <= row_last & col_last;
         end else if (consume) begin
            pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
      end else begin
         ack_s1 <= ack_nxt;
         ack_s2 <= ack_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         xt         <= '0;
         xf         <= '0;
         frame_done <= 1'b0;
         cur_last   <= 1'b0;
      end else begin
         state      <= state_nxt;
         xt         <= xt_nxt;
         xf         <= xf_nxt;
         frame_done <= done_nxt;
         if (consume)
            cur_last <= pend_last;
      end
   end

   always_comb begin
      state_nxt = state;
      xt_nxt    = xt;
      xf_nxt    = xf;
      done_nxt  = 1'b0;
      consume   = 1'b0;
      case (state)
         IDLE: begin
            xt_nxt = '0;
            xf_nxt = '0;
            if (pending && !ack_s2) begin
               consume   = 1'b1;
               state_nxt = DATA;
               xt_nxt    = win_reg;
               xf_nxt    = ~win_reg;
            end
         end
         DATA: begin
            if (ack_s2) begin
               state_nxt = RTZ;
               xt_nxt    = '0;
               xf_nxt    = '0;
            end
         end
         RTZ: begin
            xt_nxt = '0;
            xf_nxt = '0;
            if (!ack_s2) begin
               state_nxt = IDLE;
               done_nxt  = cur_last;
            end
         end
         default: begin
            state_nxt = IDLE;
            xt_nxt    = '0;
            xf_nxt    = '0;
         end
      endcase
   end

endmodule
